aclint_memory: RTL

- Memory-mapped ACLINT device: one MSWI (msip) plus one MTIMER (mtime, mtimecmp) for a single hart.
- Sits on the data-memory bus behind the address decoder.
- Drives aclint_if.master, which the CSR unit consumes as mip.MTIP, mip.MSIP and the TIME CSR.
- Single outstanding request, fixed 1-cycle response latency.

---
 rtl/aclint_memory_pkg.sv | 27 ++
 rtl/aclint_if.sv | 9 +
 rtl/aclint_tick_gen.sv | 28 ++
 rtl/aclint_memory.sv | 120 ++++++++++++
 4 files changed

// File: rtl/aclint_memory_pkg.sv
// Shared ACLINT constants (package eei): device offsets, decoder window and the byte-merge helper.
package eei;

  localparam int XLEN = 64;

  localparam logic [15:0] ACLINT_MSIP_OFS     = 16'h0000;
  localparam logic [15:0] ACLINT_MTIMECMP_OFS = 16'h4000;
  localparam logic [15:0] ACLINT_MTIME_OFS    = 16'hBFF8;

  // Window the data-memory decoder routes to this device.
  localparam logic [31:0] ACLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] ACLINT_SIZE = 32'h0001_0000;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_MTIMECMP,
    SEL_MTIME
  } aclint_sel_e;

  function automatic logic [XLEN-1:0] byte_merge(input logic [XLEN-1:0] old_v,
                                                 input logic [XLEN-1:0] wdata,
                                                 input logic [XLEN-1:0] bmask);
    return (wdata & bmask) | (old_v & ~bmask);
  endfunction

endpackage

// File: rtl/aclint_if.sv
// Timer/software-interrupt outputs consumed by the CSR unit (mip.MTIP, mip.MSIP, TIME).
interface aclint_if;
  logic        msip;
  logic        mtip;
  logic [63:0] mtime;

  modport master (output msip, output mtip, output mtime);
  modport slave  (input  msip, input  mtip, input  mtime);
endinterface

// File: rtl/aclint_tick_gen.sv
// Prescaler for mtime: emits a 1-cycle tick every TICK_DIV cycles; clr_i restarts the count.
module aclint_tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/aclint_memory.sv
// Single-hart ACLINT (MSWI + MTIMER) on the data-memory bus, 1-cycle response.
// Optional prescaled mtime via `define ACLINT_PRESCALER_EN (rate set by TICK_DIV).
module aclint_memory
  import eei::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int TICK_DIV   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_wen,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wmask,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  aclint_if.master                aclint
);

  localparam logic [ADDR_WIDTH-1:0] MSIP_A     = ADDR_WIDTH'(ACLINT_MSIP_OFS);
  localparam logic [ADDR_WIDTH-1:0] MTIMECMP_A = ADDR_WIDTH'(ACLINT_MTIMECMP_OFS);
  localparam logic [ADDR_WIDTH-1:0] MTIME_A    = ADDR_WIDTH'(ACLINT_MTIME_OFS);

  logic                  msip_q, msip_d;
  logic [63:0]           mtime_q, mtime_d;
  logic [63:0]           mtimecmp_q, mtimecmp_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic                  acc, mtime_we, tick;
  aclint_sel_e           sel;
  logic [DATA_WIDTH-1:0] bmask_w;
  logic [63:0]           wdata64, bmask64, rd_val;

  // The consumer always sinks the response in its valid cycle, so one accept per cycle is safe.
  assign req_ready = 1'b1;
  assign acc       = req_valid && req_ready;

  // Low address bits are ignored; misalignment is trapped upstream.
  always_comb begin
    sel = SEL_NONE;
    if      (req_addr[ADDR_WIDTH-1:3] == MSIP_A[ADDR_WIDTH-1:3])     sel = SEL_MSIP;
    else if (req_addr[ADDR_WIDTH-1:3] == MTIMECMP_A[ADDR_WIDTH-1:3]) sel = SEL_MTIMECMP;
    else if (req_addr[ADDR_WIDTH-1:3] == MTIME_A[ADDR_WIDTH-1:3])    sel = SEL_MTIME;
  end

  always_comb begin
    bmask_w = '0;
    for (int i = 0; i < DATA_WIDTH/8; i++) bmask_w[i*8 +: 8] = {8{req_wmask[i]}};
  end

  assign wdata64  = 64'(req_wdata);
  assign bmask64  = 64'(bmask_w);
  assign mtime_we = acc && req_wen && (sel == SEL_MTIME);

  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_MSIP:     rd_val = {63'd0, msip_q};
      SEL_MTIMECMP: rd_val = mtimecmp_q;
      SEL_MTIME:    rd_val = mtime_q;
      default:      rd_val = '0;
    endcase
  end

`ifdef ACLINT_PRESCALER_EN
  aclint_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (mtime_we),
    .tick_o (tick)
  );
`else
  localparam int unused_tick_div = TICK_DIV;
  assign tick = 1'b1;
`endif

  // Read data comes from pre-write state; an mtime write overrides that cycle's increment.
  always_comb begin
    msip_d      = msip_q;
    mtimecmp_d  = mtimecmp_q;
    mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
    rsp_valid_d = acc;
    rsp_rdata_d = acc ? DATA_WIDTH'(rd_val) : rsp_rdata_q;
    if (acc && req_wen) begin
      case (sel)
        SEL_MSIP:     if (bmask64[0]) msip_d = wdata64[0];
        SEL_MTIMECMP: mtimecmp_d = byte_merge(mtimecmp_q, wdata64, bmask64);
        SEL_MTIME:    mtime_d    = byte_merge(mtime_q, wdata64, bmask64);
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msip_q      <= 1'b0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      msip_q      <= msip_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign aclint.msip  = msip_q;
  assign aclint.mtime = mtime_q;
  assign aclint.mtip  = (mtime_q >= mtimecmp_q);

endmodule
